// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared FSM state type and default Galois tap masks for lfsr_gen
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } lfsr_state_t;

    // Right-shifting Galois masks for maximal-length polynomials.
    localparam logic [7:0]  TAPS_W8  = 8'hB8;        // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] TAPS_W16 = 16'hB400;     // x^16+x^14+x^13+x^11+1
    localparam logic [23:0] TAPS_W24 = 24'hE10000;   // x^24+x^23+x^22+x^17+1
    localparam logic [31:0] TAPS_W32 = 32'hA3000000; // x^32+x^30+x^26+x^25+1

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational single-step Galois LFSR update
// Ports:
//   cur : current register state
//   nxt : state after one step, (cur >> 1) ^ (cur[0] ? TAPS : 0)
module lfsr_next #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - Galois LFSR with free-run, load and counted burst modes
// Ports:
//   CLK       : clock, rising edge
//   RESET     : synchronous active-high reset
//   EN        : free-run step enable (ignored while BUSY)
//   LOAD      : load LOAD_VAL (zero is replaced by SEED)
//   LOAD_VAL  : value to load
//   START     : begin a burst of BURST_LEN steps (IDLE only)
//   BURST_LEN : burst step count, captured at START
//   Q         : current state
//   BUSY      : burst in progress
//   DONE      : one-cycle pulse at burst completion
//   WRAP      : one-cycle pulse when a step lands on SEED
//   ZERO_FIX  : one-cycle pulse when a zero load was replaced by SEED
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter int unsigned      CW    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             START,
    input  logic [CW-1:0]    BURST_LEN,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRAP,
    output logic             ZERO_FIX
);

    lfsr_state_t      state;
    logic [CW-1:0]    remain;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_step;
    logic             busy_reg;
    logic             done_reg;
    logic             wrap_reg;
    logic             zero_fix_reg;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .cur (q_reg),
        .nxt (q_step)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            remain       <= '0;
            q_reg        <= SEED;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
            zero_fix_reg <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            wrap_reg     <= 1'b0;
            zero_fix_reg <= 1'b0;
            if (LOAD) begin
                // A load overrides everything, aborting any burst silently.
                q_reg        <= (LOAD_VAL == '0) ? SEED : LOAD_VAL;
                zero_fix_reg <= (LOAD_VAL == '0);
                state        <= ST_IDLE;
                remain       <= '0;
                busy_reg     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (EN) begin
                            q_reg    <= q_step;
                            wrap_reg <= (q_step == SEED);
                        end
                        if (START) begin
                            if (BURST_LEN == '0) begin
                                state    <= ST_FIN;
                                done_reg <= 1'b1;
                            end else begin
                                state    <= ST_RUN;
                                remain   <= BURST_LEN;
                                busy_reg <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        q_reg    <= q_step;
                        wrap_reg <= (q_step == SEED);
                        remain   <= remain - CW'(1);
                        if (remain == CW'(1)) begin
                            state    <= ST_FIN;
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end
                    end
                    ST_FIN: begin
                        // DONE is already showing this cycle; START is ignored here.
                        if (EN) begin
                            q_reg    <= q_step;
                            wrap_reg <= (q_step == SEED);
                        end
                        state <= ST_IDLE;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q        = q_reg;
    assign BUSY     = busy_reg;
    assign DONE     = done_reg;
    assign WRAP     = wrap_reg;
    assign ZERO_FIX = zero_fix_reg;

endmodule
